reversi_turn_sequencer: RTL and testbench
=========================================

// Module: reversi_turn_sequencer
// PURPOSE
// Game-flow controller between the keyboard move/enter pulse decoder and the board engine.
// - Owns the cursor position, the side to move, pass detection and end-of-game.
// - Sequences the engine through two req/ack handshakes: "does this player have a legal move?"
//   and "place a disc at (x,y)".
// PARAMETERS
// BOARD_DIM  8     squares per side; cursor range 0..BOARD_DIM-1
// COORD_W    3     width of x/y coordinates (>= clog2(BOARD_DIM))
// WRAP       1     1: cursor wraps at edges; 0: cursor saturates at edges
// TIMEOUT    1023  max cycles to wait for any ack before abandoning the request
// PORTS
// clk           in   1        system clock, all state on rising edge
// resetn        in   1        asynchronous active-low reset
// enter         in   1        1-cycle pulse: confirm / start new game
// moveUp/Down/Left/Right in 1 1-cycle cursor pulses (four separate ports)
// chk_req       out  1        ask engine whether `player` has any legal move
// chk_ack       in   1        engine answer valid (1 cycle)
// chk_has_move  in   1        answer, sampled only when chk_ack=1
// place_req     out  1        ask engine to place a disc for `player` at place_x/place_y
// place_x/y     out  COORD_W  latched placement coordinates (two ports)
// place_ack     in   1        engine done (1 cycle)
// place_legal   in   1        1: move applied; 0: illegal, board unchanged
// cursor_x/y    out  COORD_W  current cursor for the VGA renderer (two ports)
// player        out  1        side to move: 0 = black, 1 = white
// turn_count    out  7        number of successful placements this game
// illegal       out  1        1-cycle pulse on rejected placement
// pass_evt      out  1        1-cycle pulse when a player is forced to pass
// timeout_err   out  1        1-cycle pulse when an ack does not arrive within TIMEOUT
// game_over     out  1        high while in OVER
// new_game      out  1        1-cycle pulse telling the engine to reset the board
// BEHAVIOUR
// - Reset (async, resetn=0): state=CHECK, cursor=(3,3), player=0, turn_count=0, pass_cnt=0,
//   all req/pulse outputs 0, place_x/y=0, game_over=0.
// - States: CHECK, INPUT, PLACE, OVER. Transitions are evaluated on the clock edge where the
//   condition is seen; outputs are registered.
// - CHECK: chk_req=1 until chk_ack. On ack:
//   - has_move=1: pass_cnt<=0 and go to INPUT.
//   - has_move=0: pass_evt pulse and pass_cnt++.
//     - pass_cnt was 1 -> OVER.
//     - otherwise toggle player and stay in CHECK; chk_req drops for one cycle, then re-asserts.
// - INPUT: cursor updates one step per move pulse.
//   - X and Y axes update independently; Up+Down (or Left+Right) in the same cycle cancel.
//   - Up decrements y; Left decrements x.
//   - At an edge: WRAP=1 wraps 0<->BOARD_DIM-1; WRAP=0 holds.
//   - enter: latch place_x/y from the cursor, go to PLACE. Move pulses in that same cycle are ignored.
// - PLACE: place_req=1, place_x/y stable, until place_ack.
//   - legal=1: turn_count++ (saturates at 127), toggle player, go to CHECK.
//   - legal=0: illegal pulse, go to INPUT; player and cursor unchanged.
// - Handshake rules:
//   - A req, once raised, stays high until its ack is sampled and drops the following cycle.
//   - Acks are ignored when the matching req is low.
//   - At most one req is high at any time.
// - Timeout: a counter runs while any req is high. If it reaches TIMEOUT without an ack:
//   - timeout_err pulse and req drops.
//   - PLACE returns to INPUT; CHECK restarts the query.
// - OVER: game_over=1; cursor and move pulses are ignored. enter -> new_game pulse, then the
//   reset values above (except resetn-only state) are reloaded and the state goes to CHECK.
// - An enter in any state other than INPUT or OVER is dropped (not queued).
// - resetn asserted mid-handshake aborts immediately; req goes low asynchronously.
// TESTING
// - Reset, then chk_ack with has_move=1 -> INPUT, cursor (3,3), player 0, chk_req high exactly until ack.
// - WRAP=1, cursor (0,0): moveLeft, then moveUp -> (7,7). WRAP=0: same pulses -> (0,0).
//   Up+Down together -> y unchanged.
// - enter at (2,3), place_ack legal=1 after 5 cycles -> place_x/y=(2,3) held for 5 cycles,
//   turn_count=1, player=1, back in CHECK.
// - place_ack legal=0 -> illegal pulse, player unchanged, INPUT.
//   A move pulse coincident with enter is ignored.
// - Two consecutive has_move=0 -> two pass_evt pulses, game_over=1.
//   enter -> new_game pulse, turn_count=0, player=0.
// - No ack for TIMEOUT cycles in PLACE -> timeout_err, place_req low, INPUT.
//   resetn low mid-PLACE -> all outputs at reset values.

Source files
------------

// File: rtl/reversi_turn_sequencer.sv
// Reversi game-flow controller: owns the cursor, side to move, pass detection and
// end-of-game, and sequences the board engine through check/place req-ack handshakes.
module reversi_turn_sequencer #(
    parameter int unsigned BOARD_DIM = 8,
    parameter int unsigned COORD_W   = 3,
    parameter bit          WRAP      = 1'b1,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enter,
    input  logic               moveUp,
    input  logic               moveDown,
    input  logic               moveLeft,
    input  logic               moveRight,
    output logic               chk_req,
    input  logic               chk_ack,
    input  logic               chk_has_move,
    output logic               place_req,
    output logic [COORD_W-1:0] place_x,
    output logic [COORD_W-1:0] place_y,
    input  logic               place_ack,
    input  logic               place_legal,
    output logic [COORD_W-1:0] cursor_x,
    output logic [COORD_W-1:0] cursor_y,
    output logic               player,
    output logic [6:0]         turn_count,
    output logic               illegal,
    output logic               pass_evt,
    output logic               timeout_err,
    output logic               game_over,
    output logic               new_game
);

    localparam logic [1:0] StCheck = 2'd0;
    localparam logic [1:0] StInput = 2'd1;
    localparam logic [1:0] StPlace = 2'd2;
    localparam logic [1:0] StOver  = 2'd3;

    localparam int unsigned        TIMER_W     = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(TIMEOUT - 1);
    localparam logic [COORD_W-1:0] MAX_COORD   = COORD_W'(BOARD_DIM - 1);
    localparam logic [COORD_W-1:0] CURSOR_INIT = COORD_W'(3);

    logic [1:0]         state_q, state_d;
    logic [COORD_W-1:0] cursor_x_q, cursor_x_d, cursor_y_q, cursor_y_d;
    logic [COORD_W-1:0] place_x_q, place_x_d, place_y_q, place_y_d;
    logic               player_q, player_d;
    logic [6:0]         turn_count_q, turn_count_d;
    logic               pass_cnt_q, pass_cnt_d;
    logic               chk_req_q, chk_req_d, place_req_q, place_req_d;
    logic               illegal_q, illegal_d, pass_evt_q, pass_evt_d;
    logic               timeout_q, timeout_d, game_over_q, game_over_d;
    logic               new_game_q, new_game_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    // One cursor step on a single axis; opposing pulses cancel.
    function automatic logic [COORD_W-1:0] step_coord(input logic [COORD_W-1:0] c,
                                                      input logic inc, input logic dec);
        logic [COORD_W-1:0] r;
        r = c;
        if (inc && !dec) begin
            if (c == MAX_COORD) r = WRAP ? '0 : c;
            else                r = c + COORD_W'(1);
        end else if (dec && !inc) begin
            if (c == '0) r = WRAP ? MAX_COORD : c;
            else         r = c - COORD_W'(1);
        end
        return r;
    endfunction

    // Next-state logic for the turn FSM, handshakes and timeout counter.
    always_comb begin
        state_d      = state_q;
        cursor_x_d   = cursor_x_q;
        cursor_y_d   = cursor_y_q;
        place_x_d    = place_x_q;
        place_y_d    = place_y_q;
        player_d     = player_q;
        turn_count_d = turn_count_q;
        pass_cnt_d   = pass_cnt_q;
        chk_req_d    = chk_req_q;
        place_req_d  = place_req_q;
        game_over_d  = game_over_q;
        illegal_d    = 1'b0;
        pass_evt_d   = 1'b0;
        timeout_d    = 1'b0;
        new_game_d   = 1'b0;
        timer_d      = '0;

        case (state_q)
            StCheck: begin
                if (chk_req_q) begin
                    if (chk_ack) begin
                        chk_req_d = 1'b0;
                        if (chk_has_move) begin
                            pass_cnt_d = 1'b0;
                            state_d    = StInput;
                        end else begin
                            pass_evt_d = 1'b1;
                            if (pass_cnt_q) begin
                                // Second pass in a row: neither side can move.
                                state_d     = StOver;
                                game_over_d = 1'b1;
                            end else begin
                                pass_cnt_d = 1'b1;
                                player_d   = ~player_q;
                            end
                        end
                    end else if (timer_q == TIMER_LAST) begin
                        timeout_d = 1'b1;
                        chk_req_d = 1'b0;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end else begin
                    // Req is low on entry and after a pass/timeout; raise it here.
                    chk_req_d = 1'b1;
                end
            end
            StInput: begin
                if (enter) begin
                    place_x_d   = cursor_x_q;
                    place_y_d   = cursor_y_q;
                    place_req_d = 1'b1;
                    state_d     = StPlace;
                end else begin
                    cursor_x_d = step_coord(cursor_x_q, moveRight, moveLeft);
                    cursor_y_d = step_coord(cursor_y_q, moveDown, moveUp);
                end
            end
            StPlace: begin
                if (!place_req_q) begin
                    state_d = StInput;
                end else if (place_ack) begin
                    place_req_d = 1'b0;
                    if (place_legal) begin
                        if (turn_count_q != 7'd127) turn_count_d = turn_count_q + 7'd1;
                        player_d = ~player_q;
                        state_d  = StCheck;
                    end else begin
                        illegal_d = 1'b1;
                        state_d   = StInput;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d   = 1'b1;
                    place_req_d = 1'b0;
                    state_d     = StInput;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                if (enter) begin
                    new_game_d   = 1'b1;
                    state_d      = StCheck;
                    cursor_x_d   = CURSOR_INIT;
                    cursor_y_d   = CURSOR_INIT;
                    place_x_d    = '0;
                    place_y_d    = '0;
                    player_d     = 1'b0;
                    turn_count_d = '0;
                    pass_cnt_d   = 1'b0;
                    game_over_d  = 1'b0;
                end
            end
        endcase
    end

    // State registers; reset also aborts any outstanding handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StCheck;
            cursor_x_q   <= CURSOR_INIT;
            cursor_y_q   <= CURSOR_INIT;
            place_x_q    <= '0;
            place_y_q    <= '0;
            player_q     <= 1'b0;
            turn_count_q <= '0;
            pass_cnt_q   <= 1'b0;
            chk_req_q    <= 1'b0;
            place_req_q  <= 1'b0;
            illegal_q    <= 1'b0;
            pass_evt_q   <= 1'b0;
            timeout_q    <= 1'b0;
            game_over_q  <= 1'b0;
            new_game_q   <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            cursor_x_q   <= cursor_x_d;
            cursor_y_q   <= cursor_y_d;
            place_x_q    <= place_x_d;
            place_y_q    <= place_y_d;
            player_q     <= player_d;
            turn_count_q <= turn_count_d;
            pass_cnt_q   <= pass_cnt_d;
            chk_req_q    <= chk_req_d;
            place_req_q  <= place_req_d;
            illegal_q    <= illegal_d;
            pass_evt_q   <= pass_evt_d;
            timeout_q    <= timeout_d;
            game_over_q  <= game_over_d;
            new_game_q   <= new_game_d;
            timer_q      <= timer_d;
        end
    end

    assign chk_req     = chk_req_q;
    assign place_req   = place_req_q;
    assign place_x     = place_x_q;
    assign place_y     = place_y_q;
    assign cursor_x    = cursor_x_q;
    assign cursor_y    = cursor_y_q;
    assign player      = player_q;
    assign turn_count  = turn_count_q;
    assign illegal     = illegal_q;
    assign pass_evt    = pass_evt_q;
    assign timeout_err = timeout_q;
    assign game_over   = game_over_q;
    assign new_game    = new_game_q;

endmodule

// File: tb/tb_reversi_turn_sequencer.sv
// Directed bench for reversi_turn_sequencer: a wrapping instance is fully checked and a
// saturating twin shares its stimulus to cover the cursor edge behaviour.
module tb_reversi_turn_sequencer;

    localparam int unsigned TO = 20;

    logic clk, resetn, enter, moveUp, moveDown, moveLeft, moveRight;
    logic chk_ack, chk_has_move, place_ack, place_legal;

    logic       chk_req, place_req, player, illegal, pass_evt, timeout_err, game_over, new_game;
    logic [2:0] place_x, place_y, cursor_x, cursor_y;
    logic [6:0] turn_count;

    logic       s_chk_req, s_place_req, s_player, s_illegal, s_pass_evt, s_timeout_err;
    logic       s_game_over, s_new_game;
    logic [2:0] s_place_x, s_place_y, s_cursor_x, s_cursor_y;
    logic [6:0] s_turn_count;

    int checks = 0;
    int errors = 0;

    reversi_turn_sequencer #(.BOARD_DIM(8), .COORD_W(3), .WRAP(1'b1), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn), .enter(enter),
        .moveUp(moveUp), .moveDown(moveDown), .moveLeft(moveLeft), .moveRight(moveRight),
        .chk_req(chk_req), .chk_ack(chk_ack), .chk_has_move(chk_has_move),
        .place_req(place_req), .place_x(place_x), .place_y(place_y),
        .place_ack(place_ack), .place_legal(place_legal),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .player(player), .turn_count(turn_count),
        .illegal(illegal), .pass_evt(pass_evt), .timeout_err(timeout_err),
        .game_over(game_over), .new_game(new_game)
    );

    reversi_turn_sequencer #(.BOARD_DIM(8), .COORD_W(3), .WRAP(1'b0), .TIMEOUT(TO)) dut_sat (
        .clk(clk), .resetn(resetn), .enter(enter),
        .moveUp(moveUp), .moveDown(moveDown), .moveLeft(moveLeft), .moveRight(moveRight),
        .chk_req(s_chk_req), .chk_ack(chk_ack), .chk_has_move(chk_has_move),
        .place_req(s_place_req), .place_x(s_place_x), .place_y(s_place_y),
        .place_ack(place_ack), .place_legal(place_legal),
        .cursor_x(s_cursor_x), .cursor_y(s_cursor_y), .player(s_player),
        .turn_count(s_turn_count), .illegal(s_illegal), .pass_evt(s_pass_evt),
        .timeout_err(s_timeout_err), .game_over(s_game_over), .new_game(s_new_game)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic move(input logic u, input logic d, input logic l, input logic r);
        moveUp = u; moveDown = d; moveLeft = l; moveRight = r;
        tick();
        moveUp = 1'b0; moveDown = 1'b0; moveLeft = 1'b0; moveRight = 1'b0;
    endtask

    task automatic ack_check(input logic has);
        chk_ack = 1'b1; chk_has_move = has;
        tick();
        chk_ack = 1'b0; chk_has_move = 1'b0;
    endtask

    task automatic ack_place(input logic legal);
        place_ack = 1'b1; place_legal = legal;
        tick();
        place_ack = 1'b0; place_legal = 1'b0;
    endtask

    task automatic press_enter();
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    initial begin
        int n;
        resetn = 1'b0; enter = 1'b0;
        moveUp = 1'b0; moveDown = 1'b0; moveLeft = 1'b0; moveRight = 1'b0;
        chk_ack = 1'b0; chk_has_move = 1'b0; place_ack = 1'b0; place_legal = 1'b0;
        tick();
        tick();
        check_value("rst_chk_req", chk_req, 0);
        check_value("rst_place_req", place_req, 0);
        check_value("rst_cursor_x", cursor_x, 3);
        check_value("rst_cursor_y", cursor_y, 3);
        check_value("rst_player", player, 0);
        check_value("rst_turn", turn_count, 0);
        check_value("rst_game_over", game_over, 0);

        // First check handshake: req raised, held until ack, then drops.
        resetn = 1'b1;
        tick();
        check_value("chk_req_up", chk_req, 1);
        tick();
        tick();
        check_value("chk_req_held", chk_req, 1);
        ack_check(1'b1);
        check_value("chk_req_drop", chk_req, 0);
        check_value("input_cursor_x", cursor_x, 3);
        check_value("input_player", player, 0);

        // Cursor to (0,0), then past the edges.
        for (int i = 0; i < 3; i++) move(1'b1, 1'b0, 1'b1, 1'b0);
        check_value("corner_x", cursor_x, 0);
        check_value("corner_y", cursor_y, 0);
        move(1'b0, 1'b0, 1'b1, 1'b0);
        move(1'b1, 1'b0, 1'b0, 1'b0);
        check_value("wrap_x", cursor_x, 7);
        check_value("wrap_y", cursor_y, 7);
        check_value("sat_x", s_cursor_x, 0);
        check_value("sat_y", s_cursor_y, 0);
        move(1'b1, 1'b1, 1'b0, 1'b0);
        check_value("updown_cancel_y", cursor_y, 7);
        move(1'b0, 1'b0, 1'b1, 1'b1);
        check_value("leftright_cancel_x", cursor_x, 7);

        // Walk to (2,3): x 7->0->1->2, y 7->0->1->2->3.
        for (int i = 0; i < 3; i++) move(1'b0, 1'b1, 1'b0, 1'b1);
        move(1'b0, 1'b1, 1'b0, 1'b0);
        check_value("walk_x", cursor_x, 2);
        check_value("walk_y", cursor_y, 3);

        // Enter with a coincident move: move ignored, placement latched.
        moveRight = 1'b1;
        press_enter();
        moveRight = 1'b0;
        check_value("place_req_up", place_req, 1);
        check_value("enter_move_ignored", cursor_x, 2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_value("place_req_held", place_req, 1);
            check_value("place_x_held", place_x, 2);
            check_value("place_y_held", place_y, 3);
        end
        ack_place(1'b1);
        check_value("place_req_drop", place_req, 0);
        check_value("turn_after_legal", turn_count, 1);
        check_value("player_after_legal", player, 1);
        tick();
        check_value("back_in_check", chk_req, 1);

        // Illegal placement.
        ack_check(1'b1);
        moveUp = 1'b1;
        press_enter();
        moveUp = 1'b0;
        check_value("place_req_2", place_req, 1);
        ack_place(1'b0);
        check_value("illegal_pulse", illegal, 1);
        check_value("illegal_player", player, 1);
        check_value("illegal_turn", turn_count, 1);
        check_value("illegal_cursor_y", cursor_y, 3);
        move(1'b0, 1'b0, 1'b1, 1'b0);
        check_value("illegal_pulse_end", illegal, 0);
        check_value("input_after_illegal", cursor_x, 1);

        // Legal move, then two forced passes end the game.
        press_enter();
        ack_place(1'b1);
        check_value("turn_2", turn_count, 2);
        check_value("player_0", player, 0);
        tick();
        ack_check(1'b0);
        check_value("pass1_evt", pass_evt, 1);
        check_value("pass1_player", player, 1);
        check_value("pass1_req_drop", chk_req, 0);
        tick();
        check_value("pass1_evt_end", pass_evt, 0);
        check_value("pass1_req_again", chk_req, 1);
        ack_check(1'b0);
        check_value("pass2_evt", pass_evt, 1);
        check_value("game_over", game_over, 1);
        check_value("pass2_player", player, 1);
        move(1'b0, 1'b0, 1'b1, 1'b0);
        check_value("over_cursor_frozen", cursor_x, 1);
        check_value("over_chk_req", chk_req, 0);
        press_enter();
        check_value("new_game_pulse", new_game, 1);
        check_value("new_turn", turn_count, 0);
        check_value("new_player", player, 0);
        check_value("new_game_over", game_over, 0);
        check_value("new_cursor_x", cursor_x, 3);
        tick();
        check_value("new_game_end", new_game, 0);
        check_value("new_chk_req", chk_req, 1);

        // Placement timeout.
        ack_check(1'b1);
        press_enter();
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (timeout_err) break;
        end
        check_value("timeout_cycles", n, TO);
        check_value("timeout_req_low", place_req, 0);
        move(1'b0, 1'b0, 1'b0, 1'b1);
        check_value("timeout_pulse_end", timeout_err, 0);
        check_value("input_after_timeout", cursor_x, 4);

        // Asynchronous reset mid-placement.
        press_enter();
        check_value("place_req_3", place_req, 1);
        tick();
        resetn = 1'b0;
        #1;
        check_value("async_place_req", place_req, 0);
        check_value("async_place_x", place_x, 0);
        check_value("async_cursor_x", cursor_x, 3);
        check_value("async_chk_req", chk_req, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
